// File: rtl/bloon_health_tracker.sv
// Per-wave bloon health/death tracker: merges NUM_SRC hit masks into per-slot damage,
// latches pops and leaks, counts them and flags wave completion.

module bloon_slot #(
    parameter int NUM_SRC = 8,
    parameter int HP_W    = 4
) (
    input  logic               Clk,
    input  logic               reset,
    input  logic               load,
    input  logic [HP_W-1:0]    load_hp,
    input  logic               present,
    input  logic               run,
    input  logic [NUM_SRC-1:0] hits,
    input  logic               leak,
    output logic [HP_W-1:0]    hp,
    output logic               dead,
    output logic               pop_pulse,
    output logic               pop_now,
    output logic               leak_now
);
    localparam int DMG_W = $clog2(NUM_SRC + 1);
    localparam int CMP_W = (HP_W > DMG_W) ? HP_W : DMG_W;

    logic [DMG_W-1:0] dmg;
    logic [CMP_W-1:0] dmg_ext;
    logic [CMP_W-1:0] hp_ext;
    logic             kill;

    always_comb begin
        dmg = '0;
        for (int i = 0; i < NUM_SRC; i++)
            dmg = dmg + DMG_W'(hits[i]);
    end

    // Damage can exceed the HP range, so the kill test is done at the wider width.
    assign dmg_ext  = CMP_W'(dmg);
    assign hp_ext   = CMP_W'(hp);
    assign kill     = (dmg != '0) && (dmg_ext >= hp_ext);
    assign leak_now = run && !dead && leak;
    assign pop_now  = run && !dead && !leak && kill;

    always_ff @(posedge Clk) begin
        if (reset) begin
            hp        <= '0;
            dead      <= 1'b1;
            pop_pulse <= 1'b0;
        end else if (load) begin
            hp        <= load_hp;
            dead      <= ~present;
            pop_pulse <= 1'b0;
        end else if (run) begin
            pop_pulse <= pop_now;
            if (leak_now) begin
                dead <= 1'b1;
            end else if (pop_now) begin
                dead <= 1'b1;
                hp   <= '0;
            end else if (!dead) begin
                // Only reached when dmg < hp, so the narrowed subtraction cannot wrap.
                hp <= hp - HP_W'(dmg);
            end
        end else begin
            pop_pulse <= 1'b0;
        end
    end
endmodule

module bloon_health_tracker #(
    parameter int NUM_SRC    = 8,
    parameter int NUM_BLOONS = 32,
    parameter int HP_W       = 4,
    parameter int CNT_W      = $clog2(NUM_BLOONS + 1)
) (
    input  logic                          Clk,
    input  logic                          reset,
    input  logic                          wave_load,
    input  logic [NUM_BLOONS-1:0]         wave_mask,
    input  logic [NUM_BLOONS*HP_W-1:0]    wave_hp,
    input  logic [NUM_SRC*NUM_BLOONS-1:0] hit_mask,
    input  logic [NUM_BLOONS-1:0]         leak_mask,
    output logic [NUM_BLOONS-1:0]         bloon_dead,
    output logic [NUM_BLOONS*HP_W-1:0]    bloon_hp,
    output logic [NUM_BLOONS-1:0]         pop_pulse,
    output logic [CNT_W-1:0]              pop_count,
    output logic [CNT_W-1:0]              leak_count,
    output logic                          wave_active,
    output logic                          wave_done
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]            state;
    logic                  run;
    logic [NUM_BLOONS-1:0] pop_now;
    logic [NUM_BLOONS-1:0] leak_now;
    logic [NUM_BLOONS-1:0] dead_next;
    logic [CNT_W-1:0]      pops;
    logic [CNT_W-1:0]      leaks;

    function automatic logic [CNT_W-1:0] count_ones(input logic [NUM_BLOONS-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int k = 0; k < NUM_BLOONS; k++)
            c = c + CNT_W'(v[k]);
        return c;
    endfunction

    // wave_load outranks the update, so slots only advance on a plain RUN cycle.
    assign run = (state == RUN) && !wave_load;

    for (genvar j = 0; j < NUM_BLOONS; j++) begin : g_slot
        logic [NUM_SRC-1:0] slot_hits;
        for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
            assign slot_hits[i] = hit_mask[i*NUM_BLOONS + j];
        end

        bloon_slot #(
            .NUM_SRC (NUM_SRC),
            .HP_W    (HP_W)
        ) u_slot (
            .Clk       (Clk),
            .reset     (reset),
            .load      (wave_load),
            .load_hp   (wave_hp[j*HP_W +: HP_W]),
            .present   (wave_mask[j]),
            .run       (run),
            .hits      (slot_hits),
            .leak      (leak_mask[j]),
            .hp        (bloon_hp[j*HP_W +: HP_W]),
            .dead      (bloon_dead[j]),
            .pop_pulse (pop_pulse[j]),
            .pop_now   (pop_now[j]),
            .leak_now  (leak_now[j])
        );
    end

    assign dead_next = bloon_dead | pop_now | leak_now;
    assign pops      = count_ones(pop_now);
    assign leaks     = count_ones(leak_now);

    always_ff @(posedge Clk) begin
        if (reset) begin
            state      <= IDLE;
            pop_count  <= '0;
            leak_count <= '0;
            wave_done  <= 1'b0;
        end else if (wave_load) begin
            pop_count  <= '0;
            leak_count <= '0;
            if (wave_mask == '0) begin
                state     <= DONE;
                wave_done <= 1'b1;
            end else begin
                state     <= RUN;
                wave_done <= 1'b0;
            end
        end else if (state == RUN) begin
            pop_count  <= pop_count + pops;
            leak_count <= leak_count + leaks;
            if (&dead_next) begin
                state     <= DONE;
                wave_done <= 1'b1;
            end else begin
                wave_done <= 1'b0;
            end
        end else begin
            wave_done <= 1'b0;
        end
    end

    assign wave_active = (state == RUN);
endmodule

// File: tb/tb_bloon_health_tracker.sv
// Randomized bench for bloon_health_tracker against a per-slot arithmetic reference model.

module tb_bloon_health_tracker;
    localparam int NS = 8;
    localparam int NB = 32;
    localparam int HW = 4;
    localparam int CW = 6;

    logic            Clk = 1'b0;
    logic            reset;
    logic            wave_load;
    logic [NB-1:0]   wave_mask;
    logic [NB*HW-1:0] wave_hp;
    logic [NS*NB-1:0] hit_mask;
    logic [NB-1:0]   leak_mask;
    logic [NB-1:0]   bloon_dead;
    logic [NB*HW-1:0] bloon_hp;
    logic [NB-1:0]   pop_pulse;
    logic [CW-1:0]   pop_count;
    logic [CW-1:0]   leak_count;
    logic            wave_active;
    logic            wave_done;

    bloon_health_tracker #(.NUM_SRC(NS), .NUM_BLOONS(NB), .HP_W(HW)) dut (
        .Clk(Clk), .reset(reset), .wave_load(wave_load), .wave_mask(wave_mask),
        .wave_hp(wave_hp), .hit_mask(hit_mask), .leak_mask(leak_mask),
        .bloon_dead(bloon_dead), .bloon_hp(bloon_hp), .pop_pulse(pop_pulse),
        .pop_count(pop_count), .leak_count(leak_count),
        .wave_active(wave_active), .wave_done(wave_done)
    );

    always #5 Clk = ~Clk;

    int vecs = 0;
    int errs = 0;

    // reference model: 0 idle, 1 run, 2 done
    int            m_state;
    int            m_hp [NB];
    logic [NB-1:0] m_dead, m_pulse, m_pulsed, m_prev_pulsed, m_mask;
    int            m_pc, m_lc;
    logic          m_done;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_update();
        m_prev_pulsed = m_pulsed;
        if (reset) begin
            m_state = 0; m_dead = '1; m_pulse = '0; m_pc = 0; m_lc = 0; m_done = 0;
            m_mask = '0; m_pulsed = '0;
            for (int j = 0; j < NB; j++) m_hp[j] = 0;
        end else if (wave_load) begin
            for (int j = 0; j < NB; j++) m_hp[j] = int'(wave_hp[j*HW +: HW]);
            m_dead = ~wave_mask; m_mask = wave_mask; m_pulse = '0; m_pulsed = '0;
            m_pc = 0; m_lc = 0;
            m_done  = (wave_mask == '0);
            m_state = m_done ? 2 : 1;
        end else if (m_state == 1) begin
            m_pulse = '0;
            for (int j = 0; j < NB; j++) begin
                if (!m_dead[j]) begin
                    int dmg = 0;
                    for (int i = 0; i < NS; i++) dmg += int'(hit_mask[i*NB + j]);
                    if (leak_mask[j]) begin
                        m_dead[j] = 1'b1; m_lc++;
                    end else if (dmg >= 1 && dmg >= m_hp[j]) begin
                        m_dead[j] = 1'b1; m_hp[j] = 0; m_pulse[j] = 1'b1; m_pc++;
                    end else begin
                        m_hp[j] -= dmg;
                    end
                end
            end
            m_done = &m_dead;
            if (m_done) m_state = 2;
        end else begin
            m_pulse = '0; m_done = 0;
        end
        m_pulsed |= m_pulse;
    endtask

    task automatic check_all();
        logic [NB*HW-1:0] e_hp;
        for (int j = 0; j < NB; j++) e_hp[j*HW +: HW] = m_hp[j][HW-1:0];
        chk("dead", bloon_dead, m_dead);
        chk("hp", bloon_hp, e_hp);
        chk("pop_pulse", pop_pulse, m_pulse);
        chk("pop_count", pop_count, m_pc);
        chk("leak_count", leak_count, m_lc);
        chk("wave_active", wave_active, m_state == 1);
        chk("wave_done", wave_done, m_done);
        chk("invariant", 32'(pop_count) + 32'(leak_count), $countones(m_mask & bloon_dead));
        chk("pulse_once", pop_pulse & m_prev_pulsed, 0);
    endtask

    task automatic step(input logic r, input logic ld, input logic [NB-1:0] m,
                        input logic [NB*HW-1:0] h, input logic [NS*NB-1:0] hit,
                        input logic [NB-1:0] lk);
        reset = r; wave_load = ld; wave_mask = m; wave_hp = h; hit_mask = hit; leak_mask = lk;
        @(posedge Clk);
        model_update();
        #1;
        check_all();
    endtask

    function automatic logic [NS*NB-1:0] hb(input int src, input int j);
        logic [NS*NB-1:0] v;
        v = '0;
        v[src*NB + j] = 1'b1;
        return v;
    endfunction

    localparam logic [NB*HW-1:0] HP3 = {NB{4'h3}};
    localparam logic [NB*HW-1:0] HP5 = {NB{4'h5}};

    initial begin
        logic [NS*NB-1:0] all1;
        all1 = '0;
        for (int i = 0; i < NS; i++) all1 |= hb(i, 1);

        // reset held two cycles
        step(1, 0, '0, '0, '0, '0);
        step(1, 0, '0, '0, '0, '0);
        chk("rst_dead", bloon_dead, 32'hFFFF_FFFF);
        chk("rst_hp", bloon_hp, 0);
        chk("rst_cnt", {pop_count, leak_count, wave_active, wave_done}, 0);

        // two hits then one more pops bloon 0
        step(0, 1, 32'hF, HP3, '0, '0);
        step(0, 0, '0, '0, hb(0, 0) | hb(5, 0), '0);
        chk("t2_hp0", bloon_hp[3:0], 1);
        step(0, 0, '0, '0, hb(2, 0), '0);
        chk("t2_pulse", pop_pulse, 32'h1);
        chk("t2_pc", pop_count, 1);
        chk("t2_dead", bloon_dead, 32'hFFFF_FFF1);

        // leak beats an 8-source hit
        step(0, 0, '0, '0, all1, 32'h2);
        chk("t3_lc", leak_count, 1);
        chk("t3_pc", pop_count, 1);
        chk("t3_pulse", pop_pulse, 0);

        // kill 2 and 3 together, finishing the wave
        step(0, 0, '0, '0, hb(0,2)|hb(1,2)|hb(2,2)|hb(0,3)|hb(1,3)|hb(2,3), '0);
        chk("t4_pc", pop_count, 3);
        chk("t4_done", {wave_done, wave_active}, 2'b10);
        step(0, 0, '0, '0, all1 | hb(0, 2), 32'hFFFF_FFFF);
        chk("t4_hold", {wave_done, pop_count, leak_count, bloon_dead}, {1'b0, 6'd3, 6'd1, 32'hFFFF_FFFF});

        // empty wave, then reload mid-wave discarding hits
        step(0, 1, '0, HP5, all1, '0);
        chk("t5_empty", {wave_done, wave_active}, 2'b10);
        step(0, 1, 32'hFF, HP5, '0, '0);
        step(0, 0, '0, '0, hb(0, 4) | hb(1, 4), 32'h1);
        step(0, 1, 32'hF0, HP3, all1 | hb(0, 4), 32'hF0);
        chk("t5_reload", {pop_count, leak_count, bloon_dead, bloon_hp[19:16]}, {6'd0, 6'd0, 32'hFFFF_FF0F, 4'd3});

        // random traffic with occasional reloads and resets
        for (int c = 0; c < 10000; c++) begin
            logic r, ld;
            logic [NB-1:0] m, lk;
            logic [NB*HW-1:0] h;
            logic [NS*NB-1:0] hit;
            r  = ($urandom_range(0, 1999) == 0);
            ld = (m_state != 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 299) == 0);
            m  = ($urandom_range(0, 19) == 0) ? '0 : ($urandom | $urandom);
            for (int w = 0; w < NB*HW/32; w++) h[w*32 +: 32] = $urandom;
            for (int w = 0; w < NS; w++) begin
                hit[w*32 +: 32] = $urandom & $urandom & $urandom;
                if ($urandom_range(0, 1) == 0) hit[w*32 +: 32] &= $urandom;
            end
            lk = $urandom & $urandom & $urandom & $urandom & $urandom;
            step(r, ld, m, h, hit, lk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
